// File: rtl/pkt_defs_pkg.sv
// Shared definitions for the receive-side packet path: signature, header field widths, FSM states.
// S_CSUM exists only when PKT_CHECKSUM_EN is defined.
package pkt_defs_pkg;

  localparam logic [7:0] PKT_SIG = 8'hA5;
  localparam int SIG_W  = 8;
  localparam int TYPE_W = 8;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    S_H0,
    S_H1,
`ifdef PKT_CHECKSUM_EN
    S_DATA,
    S_CSUM
`else
    S_DATA
`endif
  } pkt_rx_state_t;

endpackage

// File: rtl/word_packer_16to64.sv
// Packs four accepted 16-bit payload words MSB-first into one 64-bit output word and
// holds it in the output register until the core FIFO takes it.
module word_packer_16to64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        load_word,
  input  logic        last,
  input  logic        full,
  output logic [1:0]  lane,
  output logic [63:0] dout,
  output logic        wr_en,
  output logic        pkt_end,
  output logic        out_pending
);

  logic [47:0] pack_p0;

  assign wr_en = out_pending && !full;

  // stage p0: lane shift register; p1: output register with pending flag
  always_ff @(posedge clk) begin
    if (load_word) begin
      pack_p0 <= {pack_p0[31:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane        <= 2'd0;
      dout        <= 64'd0;
      pkt_end     <= 1'b0;
      out_pending <= 1'b0;
    end else begin
      if (load_word) begin
        lane <= lane + 2'd1;
      end
      // A load and a write in the same cycle keep the flag set for the new word.
      if (load_word && lane == 2'd3) begin
        dout        <= {pack_p0, din};
        pkt_end     <= last;
        out_pending <= 1'b1;
      end else if (wr_en) begin
        out_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/input_packet_assembler.sv
// Parses {A5,type}/length headers from the host FIFO and forwards payload as framed 64-bit words.
// Define PKT_CHECKSUM_EN to expect and verify a 16-bit sum trailer after each payload.
module input_packet_assembler
  import pkt_defs_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] dout,
  output logic        wr_en,
  input  logic        full,
  output logic        pkt_end,
  output logic [7:0]  pkt_type,
  output logic        pkt_err
);

  pkt_rx_state_t      state, next_state;
  logic [LEN_W-1:0]   n_cnt;
  logic [1:0]         lane;
  logic               out_pending;
  logic               load_word;
  logic               last;
  logic               err_set;
  logic               sig_ok;
  logic               len_ok;
`ifdef PKT_CHECKSUM_EN
  logic [15:0]        csum;
`endif

  assign rd_en  = !rst && !empty && !(out_pending && full);
  assign sig_ok = (din[15:8] == PKT_SIG);
  assign len_ok = (din != 16'd0) && (32'(din) <= MAX_LEN);

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    load_word  = 1'b0;
    last       = 1'b0;
    case (state)
      S_H0: if (rd_en) begin
        if (sig_ok) next_state = S_H1;
        else        err_set    = 1'b1;
      end
      S_H1: if (rd_en) begin
        if (len_ok) begin
          next_state = S_DATA;
        end else begin
          err_set    = 1'b1;
          next_state = S_H0;
        end
      end
      S_DATA: if (rd_en) begin
        load_word = 1'b1;
        if (lane == 2'd3 && n_cnt == 16'd1) begin
          last = 1'b1;
`ifdef PKT_CHECKSUM_EN
          next_state = S_CSUM;
`else
          next_state = S_H0;
`endif
        end
      end
`ifdef PKT_CHECKSUM_EN
      S_CSUM: if (rd_en) begin
        err_set    = (din != csum);
        next_state = S_H0;
      end
`endif
      default: next_state = S_H0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_H0;
      n_cnt    <= '0;
      pkt_type <= 8'd0;
      pkt_err  <= 1'b0;
    end else begin
      state   <= next_state;
      pkt_err <= err_set;
      if (state == S_H0 && rd_en && sig_ok) begin
        pkt_type <= din[TYPE_W-1:0];
      end
      if (state == S_H1 && rd_en) begin
        n_cnt <= len_ok ? din : '0;
      end else if (load_word && lane == 2'd3) begin
        n_cnt <= n_cnt - 16'd1;
      end
    end
  end

`ifdef PKT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (state == S_H1) begin
      csum <= 16'd0;
    end else if (load_word) begin
      csum <= csum + din;
    end
  end
`endif

  word_packer_16to64 u_packer (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .load_word   (load_word),
    .last        (last),
    .full        (full),
    .lane        (lane),
    .dout        (dout),
    .wr_en       (wr_en),
    .pkt_end     (pkt_end),
    .out_pending (out_pending)
  );

endmodule

// File: tb/tb_input_packet_assembler.sv
// Scoreboard bench for input_packet_assembler: the driver queues expected output words,
// a negedge monitor pops and compares them on every wr_en.
module tb_input_packet_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        empty;
  logic        rd_en;
  logic [63:0] dout;
  logic        wr_en;
  logic        full;
  logic        pkt_end;
  logic [7:0]  pkt_type;
  logic        pkt_err;

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [7:0]  t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   fails    = 0;
  int   err_seen = 0;
  int   exp_err  = 0;

  always #5 clk = ~clk;

  input_packet_assembler dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .empty    (empty),
    .rd_en    (rd_en),
    .dout     (dout),
    .wr_en    (wr_en),
    .full     (full),
    .pkt_end  (pkt_end),
    .pkt_type (pkt_type),
    .pkt_err  (pkt_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each written word against the head of the scoreboard.
  always @(negedge clk) begin
    if (pkt_err) err_seen++;
    if (wr_en) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got %h expected no write", dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("pkt_end", 64'(pkt_end), 64'(e.e));
        chk("pkt_type", 64'(pkt_type), 64'(e.t));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] w);
    int guard;
    guard = 0;
    din   = w;
    empty = 1'b0;
    #1;
    while (!rd_en && guard < 50) begin
      tick();
      #1;
      guard++;
    end
    if (!rd_en) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got rd_en=0 for word %h expected acceptance", w);
    end
    tick();
    empty = 1'b1;
  endtask

  task automatic push(input logic [63:0] d, input logic e, input logic [7:0] t);
    exp_t x;
    x.d = d;
    x.e = e;
    x.t = t;
    q.push_back(x);
  endtask

  // Sends a full packet with payload base, base+1, ...; csum_delta corrupts the trailer.
  task automatic send_pkt(input logic [7:0] t, input int n, input logic [15:0] base,
                          input logic [15:0] csum_delta);
    logic [15:0] w[$];
    logic [15:0] sum;
    sum = 16'd0;
    for (int i = 0; i < 4 * n; i++) begin
      w.push_back(base + 16'(i));
      sum = sum + base + 16'(i);
    end
    for (int g = 0; g < n; g++) begin
      push({w[4*g], w[4*g+1], w[4*g+2], w[4*g+3]}, (g == n - 1), t);
    end
    send({8'hA5, t});
    send(16'(n));
    for (int i = 0; i < 4 * n; i++) send(w[i]);
`ifdef PKT_CHECKSUM_EN
    send(sum + csum_delta);
`else
    if (csum_delta != 16'd0) idle(0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    empty = 1'b0;
    full  = 1'b0;
    din   = 16'hA501;
    idle(3);
    @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_pkt_end", 64'(pkt_end), 64'd0);
    chk("rst_pkt_type", 64'(pkt_type), 64'd0);
    chk("rst_pkt_err", 64'(pkt_err), 64'd0);
    tick();
    rst   = 1'b0;
    empty = 1'b1;
    idle(2);

    // Basic packet, correct trailer 0x0024 when checksum is enabled.
    send_pkt(8'h01, 2, 16'h0001, 16'h0000);
    idle(4);
    chk("err_basic", 64'(err_seen), 64'(exp_err));

    // Core FIFO full for 10 cycles with the first group pending.
    push(64'h0001_0002_0003_0004, 1'b0, 8'h01);
    push(64'h0005_0006_0007_0008, 1'b1, 8'h01);
    send(16'hA501);
    send(16'h0002);
    for (int i = 1; i <= 4; i++) send(16'(i));
    full  = 1'b1;
    din   = 16'h0005;
    empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rd_en", 64'(rd_en), 64'd0);
      chk("stall_wr_en", 64'(wr_en), 64'd0);
    end
    chk("stall_dout", dout, 64'h0001_0002_0003_0004);
    tick();
    full = 1'b0;
    for (int i = 5; i <= 8; i++) send(16'(i));
`ifdef PKT_CHECKSUM_EN
    send(16'h0024);
`endif
    idle(4);
    chk("err_stall", 64'(err_seen), 64'(exp_err));

    // Bad signature, then a valid single-group packet.
    send(16'h1234);
    exp_err++;
    send_pkt(8'h5A, 1, 16'hFFFC, 16'h0000);
    idle(4);
    chk("err_bad_sig", 64'(err_seen), 64'(exp_err));

    // Zero length, then resync.
    send(16'hA501);
    send(16'h0000);
    exp_err++;
    idle(3);
    chk("err_len0", 64'(err_seen), 64'(exp_err));
    send_pkt(8'h02, 1, 16'h0010, 16'h0000);

    // Length MAX_LEN+1, then resync.
    send(16'hA501);
    send(16'h0401);
    exp_err++;
    idle(3);
    chk("err_len_max", 64'(err_seen), 64'(exp_err));
    send_pkt(8'h03, 2, 16'h0100, 16'h0000);
    idle(4);
    chk("err_after_resync", 64'(err_seen), 64'(exp_err));

`ifdef PKT_CHECKSUM_EN
    // Trailer 0x0025 instead of 0x0024: one error pulse, data still forwarded.
    send_pkt(8'h01, 2, 16'h0001, 16'h0001);
    exp_err++;
    idle(4);
    chk("err_csum", 64'(err_seen), 64'(exp_err));
`endif

    // Reset after the 6th payload word; only the first group may appear.
    push(64'h0001_0002_0003_0004, 1'b0, 8'h07);
    send(16'hA507);
    send(16'h0002);
    for (int i = 1; i <= 6; i++) send(16'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(3);
    send_pkt(8'h08, 2, 16'h0021, 16'h0000);
    idle(6);
    chk("err_final", 64'(err_seen), 64'(exp_err));
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
